// File: rtl/present_inv_sbox_dr_if.sv
// present_inv_sbox_dr_if: dual-rail request/result bundle for the inverse S-box layer.
interface present_inv_sbox_dr_if #(parameter int NIBBLES = 16);
    logic start;
    logic [4*NIBBLES-1:0] din_u, din_c, dout_u, dout_c;
    logic busy, pre, done, fault;
    modport master (output start, din_u, din_c, input busy, pre, done, fault, dout_u, dout_c);
    modport slave (input start, din_u, din_c, output busy, pre, done, fault, dout_u, dout_c);
endinterface

// File: rtl/present_inv_sbox_dr.sv
// present_inv_sbox_dr: sequential dual-rail PRESENT inverse S-box layer with rail-pair checking.
module present_inv_sbox_dr #(
    parameter int NIBBLES = 16
) (
    input logic clk,
    input logic rst,
    present_inv_sbox_dr_if.slave bus
);
    localparam int W = 4*NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    // nibble k of this constant is INV(k)
    localparam logic [63:0] INV = 64'hA970364BD21C8FE5;
    typedef enum logic [2:0] {IDLE, CHECK, PRE, EVAL, DONE} state_t;
    state_t state, state_n;
    logic [W-1:0] cap_u, cap_c, dout_u, dout_c;
    logic [IW-1:0] idx;
    logic [3:0] x, y;
    logic fault, bad, last;
    assign x = cap_u[{idx, 2'b00} +: 4];
    assign y = INV[{x, 2'b00} +: 4];
    assign bad = |(cap_u ~^ cap_c);
    assign last = idx == IW'(NIBBLES-1);
    assign bus.dout_u = dout_u;
    assign bus.dout_c = dout_c;
    assign bus.fault = fault;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = bus.start ? CHECK : IDLE;
            CHECK: state_n = bad ? DONE : PRE;
            PRE: state_n = EVAL;
            EVAL: state_n = last ? DONE : PRE;
            default: state_n = IDLE;
        endcase
        bus.busy = state != IDLE;
        bus.pre = state == PRE;
        bus.done = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            fault <= 1'b0;
            cap_u <= '0;
            cap_c <= '0;
            dout_u <= '0;
            dout_c <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                cap_u <= bus.din_u;
                cap_c <= bus.din_c;
                dout_u <= '0;
                dout_c <= '0;
                fault <= 1'b0;
                idx <= '0;
            end
            if (state == CHECK && bad)
                fault <= 1'b1;
            if (state == EVAL) begin
                dout_u[{idx, 2'b00} +: 4] <= y;
                dout_c[{idx, 2'b00} +: 4] <= ~y;
                if (!last)
                    idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_present_inv_sbox_dr.sv
// tb_present_inv_sbox_dr: directed scoreboard bench for the dual-rail inverse S-box layer.
module tb_present_inv_sbox_dr;
    localparam int N = 16;
    localparam int W = 4*N;
    typedef struct {
        logic [W-1:0] u;
        logic [W-1:0] c;
        logic f;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [3:0] inv_t[16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                              4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
    always #5 clk = ~clk;
    present_inv_sbox_dr_if #(.NIBBLES(N)) bus ();
    present_inv_sbox_dr #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] u);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = inv_t[u[4*i +: 4]];
        return r;
    endfunction

    task automatic push(input logic [W-1:0] u, input logic [W-1:0] c);
        exp_t e;
        e.f = |(u ~^ c);
        e.u = e.f ? '0 : model(u);
        e.c = e.f ? '0 : ~model(u);
        sb.push_back(e);
    endtask

    task automatic pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed done with no expected entry");
        end else begin
            e = sb.pop_front();
            chk("sb_dout_u", bus.dout_u, e.u);
            chk("sb_dout_c", bus.dout_c, e.c);
            chk("sb_fault", bus.fault, e.f);
        end
    endtask

    // drive one request at the next edge and check every cycle until the expected done
    task automatic run(input logic [W-1:0] u, input logic [W-1:0] c, input bit hold);
        logic f;
        logic [W-1:0] m;
        logic [7:0] lo_c;
        int last;
        bit seen;
        f = |(u ~^ c);
        m = model(u);
        lo_c = ~m[7:0];
        last = f ? 2 : 2*N+2;
        @(negedge clk);
        bus.din_u = u;
        bus.din_c = c;
        bus.start = 1'b1;
        push(u, c);
        if (hold) push(u, c);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !hold) begin
                bus.start = 1'b0;
                bus.din_u = ~u;
                bus.din_c = u;
            end
            chk("busy", bus.busy, 1'b1);
            chk("pre", bus.pre, !f && cyc >= 2 && cyc <= 2*N && cyc % 2 == 0);
            chk("done", bus.done, cyc == last);
            if (!f && cyc == 7) begin
                chk("mon_lo_u", bus.dout_u[7:0], m[7:0]);
                chk("mon_lo_c", bus.dout_c[7:0], lo_c);
                chk("mon_hi_spacer", bus.dout_u[W-1:8] | bus.dout_c[W-1:8], '0);
            end
            if (bus.done) pop();
        end
        if (hold) begin
            @(negedge clk);
            chk("b2b_idle", bus.busy, 1'b0);
            @(negedge clk);
            chk("b2b_busy", bus.busy, 1'b1);
            bus.start = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 2*N+4 && !seen; k++) begin
                @(negedge clk);
                if (bus.done) begin
                    seen = 1'b1;
                    pop();
                end
            end
            chk("b2b_done_seen", seen, 1'b1);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        bit seen;
        bus.start = 1'b0;
        bus.din_u = '0;
        bus.din_c = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pre", bus.pre, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        chk("rst_dout_u", bus.dout_u, '0);
        chk("rst_dout_c", bus.dout_c, '0);
        rst = 1'b0;

        run(64'h0, ~64'h0, 1'b0);
        chk("zero_u", bus.dout_u, 64'h5555555555555555);
        chk("zero_c", bus.dout_c, 64'hAAAAAAAAAAAAAAAA);

        run(64'h0123456789ABCDEF, ~64'h0123456789ABCDEF, 1'b0);
        chk("ramp_u", bus.dout_u, 64'h5EF8C12DB463079A);
        chk("ramp_c", bus.dout_c, ~64'h5EF8C12DB463079A);

        run(64'hC56B90AD3EF84712, ~64'hC56B90AD3EF84712, 1'b0);
        chk("roundtrip_u", bus.dout_u, 64'h0123456789ABCDEF);

        v = 64'h0123456789ABCDEF;
        run(v, ~v | (64'h1 << 17), 1'b0);
        chk("viol_u", bus.dout_u, '0);
        chk("viol_c", bus.dout_c, '0);
        @(negedge clk);
        chk("viol_idle", bus.busy, 1'b0);
        chk("viol_sticky", bus.fault, 1'b1);

        v = {$urandom, $urandom};
        run(v, ~v, 1'b0);
        chk("fault_cleared", bus.fault, 1'b0);

        v = {$urandom, $urandom};
        run(v, ~v, 1'b1);

        v = {$urandom, $urandom};
        @(negedge clk);
        bus.din_u = v;
        bus.din_c = ~v;
        bus.start = 1'b1;
        push(v, ~v);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            bus.start = cyc == 4;
            chk("abort_busy", bus.busy, 1'b1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_pre", bus.pre, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_dout_u", bus.dout_u, '0);
        chk("arst_dout_c", bus.dout_c, '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2*N+8; k++) begin
            @(negedge clk);
            seen |= bus.done | bus.busy;
        end
        chk("arst_no_done", seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
